// File: rtl/wb_sched_if.sv
// Instruction-scheduler handshake bundle: decoded-instruction inputs, wait-state completions,
// flush, and the register-write control outputs.
interface wb_sched_if;
   logic       start;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_done;
   logic       md_done;
   logic       flush;
   logic [1:0] RegDstControl;
   logic       RegWrite;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output start, opcode, funct, mem_done, md_done, flush,
      input  RegDstControl, RegWrite, busy, done, err
   );

   modport slave (
      input  start, opcode, funct, mem_done, md_done, flush,
      output RegDstControl, RegWrite, busy, done, err
   );
endinterface

// File: rtl/wb_sched.sv
// Multi-cycle writeback scheduler: classifies a decoded instruction and sequences
// EXEC / memory or mult-div wait / register write. Optional wait timeout: WB_SCHED_TIMEOUT_EN.
module wb_sched (
   input logic       clk,
   input logic       reset,
   wb_sched_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StExec, StWaitMem, StWaitMd, StWrite, StDone
   } state_e;

   typedef enum logic [2:0] {
      ClsNone, ClsWrite, ClsMem, ClsMd, ClsIllegal
   } cls_e;

   state_e     state_q, state_d;
   cls_e       cls_q, dec_cls;
   logic [1:0] dst_q, dec_dst;
   logic       waiting, wait_hit, timeout, tmo_q;

   // Destination codes: 00=$29, 01=rt, 10=$31, 11=rd.
   always_comb begin
      dec_cls = ClsIllegal;
      dec_dst = 2'b00;
      case (bus.opcode)
         6'h00: begin
            if (bus.funct == 6'h08) begin
               dec_cls = ClsNone;
            end else if (bus.funct == 6'h18 || bus.funct == 6'h1A) begin
               dec_cls = ClsMd;
            end else begin
               dec_cls = ClsWrite;
               dec_dst = 2'b11;
            end
         end
         6'h20, 6'h21, 6'h23: begin
            dec_cls = ClsMem;
            dec_dst = 2'b01;
         end
         6'h08, 6'h09, 6'h0A, 6'h0F: begin
            dec_cls = ClsWrite;
            dec_dst = 2'b01;
         end
         6'h03: begin
            dec_cls = ClsWrite;
            dec_dst = 2'b10;
         end
         6'h02, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: dec_cls = ClsNone;
         default: dec_cls = ClsIllegal;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cls_q <= ClsNone;
         dst_q <= 2'b00;
      end else if (state_q == StIdle && bus.start) begin
         cls_q <= dec_cls;
         dst_q <= dec_dst;
      end
   end

   assign waiting  = (state_q == StWaitMem) || (state_q == StWaitMd);
   assign wait_hit = (state_q == StWaitMem && bus.mem_done) || (state_q == StWaitMd && bus.md_done);

`ifdef WB_SCHED_TIMEOUT_EN
   logic [7:0] cnt_q;

   assign timeout = waiting && (cnt_q == 8'hFF);

   // Counter is cleared in EXEC so it reads zero on the first waiting cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 8'h00;
         tmo_q <= 1'b0;
      end else begin
         if (state_q == StExec) begin
            cnt_q <= 8'h00;
         end else if (waiting) begin
            cnt_q <= cnt_q + 8'd1;
         end
         if (state_q == StIdle) begin
            tmo_q <= 1'b0;
         end else if (timeout && !wait_hit && !bus.flush) begin
            tmo_q <= 1'b1;
         end
      end
   end
`else
   assign timeout = 1'b0;
   assign tmo_q   = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush && state_q != StIdle) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: if (bus.start) state_d = StExec;
            StExec: begin
               if (cls_q == ClsMem)        state_d = StWaitMem;
               else if (cls_q == ClsMd)    state_d = StWaitMd;
               else if (cls_q == ClsWrite) state_d = StWrite;
               else                        state_d = StDone;
            end
            StWaitMem: begin
               if (bus.mem_done)  state_d = StWrite;
               else if (timeout)  state_d = StDone;
            end
            StWaitMd:  if (bus.md_done || timeout) state_d = StDone;
            StWrite:   state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      bus.busy          = (state_q != StIdle);
      bus.RegWrite      = (state_q == StWrite) && !bus.flush;
      bus.done          = (state_q == StDone) && !bus.flush;
      bus.err           = (state_q == StDone) && !bus.flush && (cls_q == ClsIllegal || tmo_q);
      bus.RegDstControl = (state_q == StIdle) ? 2'b00 : dst_q;
   end

endmodule
